cpu_port_peer: RTL
==================

# cpu_port_peer

External-side peer for the processor's port/interrupt pins. Feeds host bytes into the CPU's `In_port` one at a time, raising `int` for each and holding the byte until software acknowledges by toggling `Out_port[7]`. Returns `Out_port[6:0]` payloads to the host on a valid/ready stream. Sits at the top level beside `top`, wired to its `In_port`, `int`, `Out_port` and `HLT`.

## Interface
Parameters:
- `DEPTH`, 4: host-to-CPU FIFO entries. Power of two, at least 2.
- `INT_CYCLES`, 2: cycles `cpu_int` is held high per raise. Range 1..15.
- `TIMEOUT`, 255: WAIT_ACK cycles before a retry. Range 1..255; 8-bit counter.
- `MAX_RETRY`, 3: retries before the byte is dropped. Range 1..7.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `h_in_valid` in 1: host byte valid.
- `h_in_data` in 8: host byte.
- `h_in_ready` out 1: equals `!full`.
- `cpu_in_port` out 8: byte presented to the CPU `In_port`.
- `cpu_int` out 1: registered interrupt to the CPU `int`.
- `cpu_out_port` in 8: CPU `Out_port`. Bit 7 is the toggle; bits 6:0 are the payload.
- `cpu_hlt` in 1: CPU `HLT`.
- `h_out_valid` out 1: payload valid to host.
- `h_out_data` out 7: payload to host.
- `h_out_ready` in 1: host accepts payload.
- `err_timeout` out 1: sticky. Set when a byte is dropped after `MAX_RETRY` retries.
- `err_overflow` out 1: sticky. Set when a payload is lost.
- `fifo_count` out clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **Reset values:** `cpu_in_port`=0x00, `cpu_int`=0, `h_in_ready`=1, `h_out_valid`=0, `h_out_data`=0, both error flags 0, `fifo_count`=0, `prev_t`=0, state IDLE.
- **Toggle detect:** `tog = cpu_out_port[7] ^ prev_t`. `prev_t` is updated every cycle.
- **Host push:** on `h_in_valid & h_in_ready`. A push while full is impossible because ready is low, even if a pop happens in the same cycle.
- **FSM IDLE:** if FIFO is non-empty and `!cpu_hlt`, load the head into `cpu_in_port`, clear the retry count, and go to RAISE.
- **FSM RAISE:** `cpu_int`=1 for `INT_CYCLES` cycles, then go to WAIT_ACK.
  - A `tog` during RAISE counts as an ack: drop `cpu_int` and go to POP.
- **FSM WAIT_ACK:** on `tog`, go to POP.
  - If the timer reaches `TIMEOUT` with no toggle: increment the retry count and go to RAISE.
  - If the retry count already equals `MAX_RETRY`: set `err_timeout` and go to POP.
- **FSM POP:** dequeue the head and go to GAP.
- **FSM GAP:** one idle cycle, then IDLE.
- **Byte hold:** `cpu_in_port` holds its value from IDLE exit through POP. It keeps the last value afterwards.
- **Halt:** `cpu_hlt` blocks only the IDLE exit. A sequence already in progress completes.
- **Return path:** every `tog`, in any state, captures `cpu_out_port[6:0]` into `h_out_data` and sets `h_out_valid`.
  - `h_out_valid` clears on `h_out_valid & h_out_ready`.
  - If `tog` arrives while `h_out_valid` is set and `h_out_ready`=0, overwrite the data and set `err_overflow`.
  - `tog` together with a handshake in the same cycle is not an overflow; the new payload stays valid.
- **Spurious ack:** a `tog` in IDLE or GAP is delivered to the host only. It has no FSM effect.
- **Reset mid-operation:** everything returns to reset values and the FIFO is emptied. The CPU sees `cpu_int` fall asynchronously.

## Timing
- `cpu_int` is registered. On an empty FIFO it rises at edge t+2 after a push accepted at edge t:
  - t+1: count updates.
  - t+2: IDLE to RAISE.
- `cpu_in_port` is stable no later than the edge on which `cpu_int` rises.
- Minimum per-byte cost is 1 (IDLE) + 1 (RAISE, early ack) + 1 (POP) + 1 (GAP) = 4 cycles.
- A payload reaches the host one cycle after `Out_port[7]` changes.
- The WAIT_ACK timer counts from 0 on each entry. A timeout fires on the cycle the count equals `TIMEOUT`; `tog` on that same cycle wins.
- `h_in_ready` and `fifo_count` update on the edge after a push or pop.

## Structure
- The shared package `cpu_port_peer_pkg` holds:
  - state encodings IDLE, RAISE, WAIT_ACK, POP, GAP (3 bits);
  - default parameter constants;
  - the toggle bit index, 7.
- Sub-module `port_fifo`: synchronous FIFO with DEPTH and WIDTH=8, push/pop/full/empty/count, asynchronous active-low `rst`.
- Everything else lives in `cpu_port_peer`: FSM, timers, return register and sticky flags.

## Test plan
- **Single byte:** after reset, push 0xA5 → `cpu_int` rises 2 cycles later, `cpu_in_port`=0xA5, `cpu_int` high for 2 cycles. Toggle `Out_port` to 0x80 → `fifo_count` returns to 0 and `h_out_data`=0x00 with valid.
- **Burst:** push 0x11, 0x22, 0x33, 0x44, 0x55 with valid held high → `h_in_ready` drops after 4 accepted, the fifth is accepted after the first ack, and bytes appear in order with one interrupt each.
- **Timeout:** push 0x3C and never toggle → 4 raises separated by 255-cycle waits, then `err_timeout`=1 and the FIFO is empty.
- **Return backpressure:** `h_out_ready`=0, then `Out_port` goes 0x81 then 0x05 → `h_out_data`=0x05 and `err_overflow`=1.
- **Halt:** `cpu_hlt`=1, push 0x7E → `cpu_int` stays 0. Drop `cpu_hlt` → raise occurs next cycle.
- **Mid-RAISE reset:** assert `rst` low during RAISE → `cpu_int` goes to 0 immediately and `fifo_count`=0. After release, the first push behaves as in the single-byte scenario.

Source files
------------

// File: rtl/cpu_port_peer_pkg.sv
// Shared definitions for the CPU port peer: FSM encoding, default
// parameter values and the Out_port bit layout.
package cpu_port_peer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAISE    = 3'd1,
        WAIT_ACK = 3'd2,
        POP      = 3'd3,
        GAP      = 3'd4
    } state_t;

    localparam int DEF_DEPTH      = 4;
    localparam int DEF_INT_CYCLES = 2;
    localparam int DEF_TIMEOUT    = 255;
    localparam int DEF_MAX_RETRY  = 3;

    // Out_port[7] is the software ack toggle; bits below it are payload.
    localparam int TOG_BIT   = 7;
    localparam int PAYLOAD_W = TOG_BIT;

    localparam int INT_CNT_W   = 4;
    localparam int TIMER_W     = 8;
    localparam int RETRY_W     = 3;

endpackage

// File: rtl/port_fifo.sv
// Synchronous FIFO holding host bytes until the CPU acknowledges them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module port_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_count   = w_count;
    assign o_full    = (w_count == (AW + 1)'(DEPTH));
    assign o_empty   = (w_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage is not reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_port_peer.sv
// External peer for the CPU port pins: feeds host bytes to In_port with an
// interrupt handshake and returns Out_port payloads to the host.
module cpu_port_peer
    import cpu_port_peer_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int INT_CYCLES = DEF_INT_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int MAX_RETRY  = DEF_MAX_RETRY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     h_in_valid,
    input  logic [7:0]               h_in_data,
    output logic                     h_in_ready,
    output logic [7:0]               cpu_in_port,
    output logic                     cpu_int,
    input  logic [7:0]               cpu_out_port,
    input  logic                     cpu_hlt,
    output logic                     h_out_valid,
    output logic [PAYLOAD_W-1:0]     h_out_data,
    input  logic                     h_out_ready,
    output logic                     err_timeout,
    output logic                     err_overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam logic [INT_CNT_W-1:0] INT_LAST    = INT_CNT_W'(INT_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   TIMEOUT_V   = TIMER_W'(TIMEOUT);
    localparam logic [RETRY_W-1:0]   MAX_RETRY_V = RETRY_W'(MAX_RETRY);

    state_t                 r_state;
    logic [7:0]             r_cpu_in_port;
    logic                   r_cpu_int;
    logic [INT_CNT_W-1:0]   r_int_cnt;
    logic [TIMER_W-1:0]     r_timer;
    logic [RETRY_W-1:0]     r_retry;
    logic                   r_err_timeout;

    logic                   r_prev_t;
    logic                   r_out_valid;
    logic [PAYLOAD_W-1:0]   r_out_data;
    logic                   r_err_overflow;

    logic                   w_tog;
    logic [PAYLOAD_W-1:0]   w_payload;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [7:0]             w_head;

    assign w_tog     = cpu_out_port[TOG_BIT] ^ r_prev_t;
    assign w_payload = cpu_out_port[PAYLOAD_W-1:0];
    assign w_push    = h_in_valid && !w_full;
    assign w_pop     = (r_state == POP);

    assign h_in_ready   = !w_full;
    assign cpu_in_port  = r_cpu_in_port;
    assign cpu_int      = r_cpu_int;
    assign h_out_valid  = r_out_valid;
    assign h_out_data   = r_out_data;
    assign err_timeout  = r_err_timeout;
    assign err_overflow = r_err_overflow;

    port_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (h_in_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Delivery FSM; cpu_int is driven from a register so the CPU never sees glitches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_cpu_in_port <= '0;
            r_cpu_int     <= 1'b0;
            r_int_cnt     <= '0;
            r_timer       <= '0;
            r_retry       <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty && !cpu_hlt) begin
                        r_cpu_in_port <= w_head;
                        r_retry       <= '0;
                        r_int_cnt     <= '0;
                        r_cpu_int     <= 1'b1;
                        r_state       <= RAISE;
                    end
                end
                RAISE: begin
                    if (w_tog) begin
                        r_cpu_int <= 1'b0;
                        r_state   <= POP;
                    end else if (r_int_cnt == INT_LAST) begin
                        r_cpu_int <= 1'b0;
                        r_timer   <= '0;
                        r_state   <= WAIT_ACK;
                    end else begin
                        r_int_cnt <= r_int_cnt + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    // An ack on the timeout cycle takes priority over the retry.
                    if (w_tog) begin
                        r_state <= POP;
                    end else if (r_timer == TIMEOUT_V) begin
                        if (r_retry == MAX_RETRY_V) begin
                            r_err_timeout <= 1'b1;
                            r_state       <= POP;
                        end else begin
                            r_retry   <= r_retry + 1'b1;
                            r_int_cnt <= '0;
                            r_cpu_int <= 1'b1;
                            r_state   <= RAISE;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                POP: begin
                    r_state <= GAP;
                end
                GAP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Return path runs in every state, independent of the delivery FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_t       <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            r_prev_t <= cpu_out_port[TOG_BIT];
            if (w_tog) begin
                r_out_data  <= w_payload;
                r_out_valid <= 1'b1;
                if (r_out_valid && !h_out_ready) begin
                    r_err_overflow <= 1'b1;
                end
            end else if (r_out_valid && h_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
